dmem_sized: RTL and testbench
=============================

Name: dmem_sized

Overview:
- Parametrised byte-addressed data memory that succeeds the fixed 32-bit, word-only data memory.
- Adds configurable depth, byte/half/word access sizes with byte lanes and sign/zero extension, and a registered read pipeline of configurable latency.
- Adds a request/valid handshake and error reporting for range and alignment faults.
- Sits between the MIPS datapath's MEM stage and the load/store unit; big-endian byte order throughout.

Parameters:
- SIZE, 32'h0800, memory depth in bytes; must be a multiple of 4.
- ADDR_W, 32, address port width.
- READ_LAT, 1, read latency in cycles from accepted request to rvalid; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request strobe; accepted when req && ready at posedge.
- we  input  1  1 = store, 0 = load.
- size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved (raises error).
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- address  input  ADDR_W  byte address.
- write_data  input  32  store data; sourced from the low bits (byte [7:0], half [15:0], word [31:0]).
- ready  output  1  can accept a request this cycle.
- rvalid  output  1  one-cycle pulse: load result on read_data.
- read_data  output  32  extended load result; holds its last value when rvalid = 0.
- error  output  1  one-cycle pulse: faulted request, aligned with the slot where rvalid would have been.

Behaviour:
- Reset (async): ready = 0, rvalid = 0, read_data = 0, error = 0; pipeline valid bits cleared; memory contents untouched. Memory is zero-initialised at elaboration only.
- ready rises on the first posedge after reset deasserts, then stays 1. There is no backpressure and one request is accepted per cycle.
- Fault check at acceptance:
  - fault = size == 11, OR address + bytes - 1 >= SIZE, OR misaligned (see Optional Feature).
  - A faulted store writes nothing.
  - A faulted load or store pulses error exactly READ_LAT cycles after acceptance; no rvalid is produced.
- Store:
  - Memory is written at the accepting posedge.
  - Big endian: byte at address = MSB of the sized datum. Half writes address and address+1 = write_data[15:8], [7:0]. Word writes address..address+3 = write_data[31:24]..[7:0].
  - No rvalid is produced.
- Load:
  - Memory is read at the accepting posedge into stage 1, then shifted through READ_LAT-1 further registers.
  - rvalid and read_data update together, READ_LAT cycles after acceptance.
  - Extension: byte -> bit 7 replicated into [31:8] if sign_ext, else zeros. Half -> bit 15 into [31:16] likewise. Word ignores sign_ext.
- Same-cycle hazard: a load accepted the cycle after a store to an overlapping byte returns the new data, because the write has completed at the earlier edge. No forwarding is needed within one request.
- Back-to-back loads produce back-to-back rvalid pulses, in order.
- Reset mid-operation: in-flight loads are dropped, with no rvalid and no error; a store already clocked in remains written.
- Address arithmetic is done in ADDR_W+1 bits, so address + 3 near 2^ADDR_W cannot wrap into range.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: half with address[0] = 1, or word with address[1:0] != 0, is a fault. Behaviour is as for any fault: error pulse, no write, no rvalid.
- Undefined: the address is aligned down before use (half clears bit 0, word clears bits [1:0]) and the access proceeds normally; misalignment never raises error. Range and reserved-size faults still apply.

Test Plan:
- Reset and latency: assert reset mid-stream with loads in flight -> rvalid = 0, read_data = 0, ready = 0; ready = 1 one edge after release. With READ_LAT = 3, a load issued at cycle t gives rvalid at t+3.
- Store word then byte loads: store word 0xA1B2C3D4 at address 0x10. Load bytes 0x10..0x13 with sign_ext = 0 -> 0xA1, 0xB2, 0xC3, 0xD4. Load byte 0x10 with sign_ext = 1 -> 0xFFFFFFA1.
- Half store and merge: store half 0x8001 at 0x22 over word 0 at 0x20. Load word 0x20 -> 0x00008001. Load half 0x22 signed -> 0xFFFF8001; unsigned -> 0x00008001.
- Range fault: word load at SIZE-2 -> error pulse at READ_LAT, no rvalid. Word store at SIZE is dropped; the next valid reads are unchanged.
- Misalignment:
  - With DMEM_MISALIGN_TRAP_EN, word load at 0x11 -> error.
  - Without it, the same load returns the word at 0x10 = 0xA1B2C3D4.
  - size = 11 -> error in both builds.
- Streaming: alternate store and load to the same address every cycle for 16 cycles -> every load returns the value stored the cycle before, with in-order, gapless rvalid pulses.

Source files
------------

// File: rtl/dmem_sized_if.sv
// Request/response bundle between the MEM stage and dmem_sized.
// The master drives the request fields; the slave returns ready, rvalid, read_data and error.
interface dmem_sized_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] address;
    logic [31:0]       write_data;
    logic              ready;
    logic              rvalid;
    logic [31:0]       read_data;
    logic              error;

    modport master (
        output req, we, size, sign_ext, address, write_data,
        input  ready, rvalid, read_data, error
    );

    modport slave (
        input  req, we, size, sign_ext, address, write_data,
        output ready, rvalid, read_data, error
    );
endinterface

// File: rtl/dmem_sized.sv
// Byte-addressed big-endian data memory: byte/half/word accesses, READ_LAT-cycle load pipeline, fault pulses.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being aligned down.
module dmem_sized #(
    parameter int unsigned SIZE     = 32'h0800,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    dmem_sized_if.slave bus
);
    localparam int unsigned WORDS = SIZE / 4;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_W:0] SIZE_X = (ADDR_W+1)'(SIZE);

    typedef struct packed {
        logic       vld;
        logic       err;
        logic [1:0] sz;
        logic [1:0] off;
        logic       sx;
    } meta_t;

    // Storage is word-wide with byte lanes; lane 3 holds the lowest byte address.
    logic [31:0] mem_q [WORDS];

    logic                      ready_q;
    logic [31:0]               hold_q;
    meta_t [READ_LAT:1]        meta_q;
    logic  [READ_LAT:1][31:0]  word_q;

    logic [2:0]        nbytes_c;
    logic [ADDR_W:0]   last_addr_c;
    logic              misalign_c;
    logic              fault_c;
    logic [IDX_W+1:0]  addr_lo_c;
    logic [IDX_W-1:0]  idx_c;
    logic              accept_c;
    logic              wr_en_c;
    logic              rd_en_c;
    logic [3:0]        be_c;
    logic [31:0]       wword_c;
    meta_t             meta_in_c;
    meta_t [READ_LAT:0]        meta_chain_c;
    logic  [READ_LAT:0][31:0]  word_chain_c;

    // Request decode: size, range and alignment.
    always_comb begin
        case (bus.size)
            2'b00:   nbytes_c = 3'd1;
            2'b01:   nbytes_c = 3'd2;
            default: nbytes_c = 3'd4;
        endcase
        last_addr_c = {1'b0, bus.address} + (ADDR_W+1)'(nbytes_c) - (ADDR_W+1)'(1);
        misalign_c  = ((bus.size == 2'b01) && bus.address[0]) ||
                      ((bus.size == 2'b10) && (bus.address[1:0] != 2'b00));
        addr_lo_c   = bus.address[IDX_W+1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        fault_c = (bus.size == 2'b11) || (last_addr_c >= SIZE_X) || misalign_c;
`else
        fault_c = (bus.size == 2'b11) || (last_addr_c >= SIZE_X);
        if (misalign_c) begin
            addr_lo_c[1:0] = (bus.size == 2'b01) ? {bus.address[1], 1'b0} : 2'b00;
        end
`endif
    end

    assign idx_c    = addr_lo_c[IDX_W+1:2];
    assign accept_c = bus.req && ready_q;
    assign wr_en_c  = accept_c && bus.we && !fault_c;
    assign rd_en_c  = accept_c && !bus.we && !fault_c;

    // Replicate the sized datum across lanes and enable only the lanes it covers.
    always_comb begin
        case (bus.size)
            2'b00: begin
                be_c    = 4'b1000 >> addr_lo_c[1:0];
                wword_c = {4{bus.write_data[7:0]}};
            end
            2'b01: begin
                be_c    = addr_lo_c[1] ? 4'b0011 : 4'b1100;
                wword_c = {2{bus.write_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wword_c = bus.write_data;
            end
        endcase
    end

    always_comb begin
        meta_in_c     = '0;
        meta_in_c.vld = rd_en_c;
        meta_in_c.err = accept_c && fault_c;
        meta_in_c.sz  = bus.size;
        meta_in_c.off = addr_lo_c[1:0];
        meta_in_c.sx  = bus.sign_ext;
    end

    // Element 0 of each chain is the input to stage 1.
    assign meta_chain_c = {meta_q, meta_in_c};
    assign word_chain_c = {word_q, 32'h0};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_c && be_c[i]) begin
                mem_q[idx_c][8*i +: 8] <= wword_c[8*i +: 8];
            end
        end
        word_q <= word_chain_c[READ_LAT-1:0];
        // Stage 1 is the registered memory read; it overrides the zero shifted in above.
        if (rd_en_c) begin
            word_q[1] <= mem_q[idx_c];
        end
    end

    logic [1:0]  last_lane_c;
    logic [31:0] shifted_c;
    logic [31:0] ext_c;
    meta_t       out_m_c;

    assign out_m_c = meta_q[READ_LAT];

    // Right-justify the sized datum by its last byte lane, then extend.
    always_comb begin
        case (out_m_c.sz)
            2'b00:   last_lane_c = out_m_c.off;
            2'b01:   last_lane_c = {out_m_c.off[1], 1'b1};
            default: last_lane_c = 2'b11;
        endcase
        shifted_c = word_q[READ_LAT] >> {~last_lane_c, 3'b000};
        case (out_m_c.sz)
            2'b00:   ext_c = {{24{out_m_c.sx & shifted_c[7]}}, shifted_c[7:0]};
            2'b01:   ext_c = {{16{out_m_c.sx & shifted_c[15]}}, shifted_c[15:0]};
            default: ext_c = shifted_c;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            hold_q  <= '0;
            meta_q  <= '0;
        end else begin
            ready_q <= 1'b1;
            meta_q  <= meta_chain_c[READ_LAT-1:0];
            if (out_m_c.vld) begin
                hold_q <= ext_c;
            end
        end
    end

    assign bus.ready     = ready_q;
    assign bus.rvalid    = out_m_c.vld;
    assign bus.error     = out_m_c.err;
    assign bus.read_data = out_m_c.vld ? ext_c : hold_q;
endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized: a byte-array reference model predicts every response,
// a negedge monitor pops and compares data, kind and arrival cycle.
module tb_dmem_sized;
    localparam int unsigned SIZE     = 32'h0800;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned READ_LAT = 3;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_sized_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_sized #(.SIZE(SIZE), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          err;
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  ref_mem [SIZE];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [31:0] last_rd  = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int nbytes(bit [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_fault(bit [1:0] sz, logic [31:0] a);
        longint last;
        if (sz == 2'b11) return 1'b1;
        last = longint'(a) + longint'(nbytes(sz)) - 1;
        if (last >= longint'(SIZE)) return 1'b1;
        if (TRAP && ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_base(bit [1:0] sz, logic [31:0] a);
        if (TRAP) return int'(a);
        return int'(a) & ~(nbytes(sz) - 1);
    endfunction

    function automatic logic [31:0] model_load(bit [1:0] sz, bit sx, logic [31:0] a);
        int          nb   = nbytes(sz);
        int          base = model_base(sz, a);
        logic [31:0] v    = 32'h0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[base + i]);
        if (sx && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        return v;
    endfunction

    function automatic void model_store(bit [1:0] sz, logic [31:0] a, logic [31:0] wd);
        int nb   = nbytes(sz);
        int base = model_base(sz, a);
        for (int i = 0; i < nb; i++) ref_mem[base + i] = 8'(wd >> (8 * (nb - 1 - i)));
    endfunction

    // Called at posedge+1; the request is accepted at the next edge.
    task automatic issue(bit w, bit [1:0] sz, bit sx, logic [31:0] a, logic [31:0] wd,
                         string name, bit use_c = 1'b0, logic [31:0] cval = 32'h0);
        exp_t e;
        bus.req        = 1'b1;
        bus.we         = w;
        bus.size       = sz;
        bus.sign_ext   = sx;
        bus.address    = a;
        bus.write_data = wd;
        e.name = name;
        e.due  = cyc + READ_LAT;
        e.data = 32'h0;
        if (model_fault(sz, a)) begin
            e.err = 1'b1;
            sb.push_back(e);
        end else if (!w) begin
            e.err  = 1'b0;
            e.data = use_c ? cval : model_load(sz, sx, a);
            sb.push_back(e);
        end else begin
            model_store(sz, a, wd);
        end
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    task automatic idle(int n);
        bus.req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: late entries are reported missing, outputs are matched against the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                n_checks++;
                $display("FAIL %s missing: no response at cycle %0d, required at %0d", sb[0].name, cyc, sb[0].due);
                void'(sb.pop_front());
            end
            if (bus.rvalid || bus.error) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL stray response: rvalid=%b error=%b data=%h, required none", bus.rvalid, bus.error, bus.read_data);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_kind"}, {30'h0, bus.rvalid, bus.error}, mon_e.err ? 32'd1 : 32'd2);
                    check({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.due));
                    if (!mon_e.err) begin
                        check({mon_e.name, "_data"}, bus.read_data, mon_e.data);
                        last_rd = mon_e.data;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        bit          w;
        bit [1:0]    sz;
        int          r;

        for (int i = 0; i < SIZE; i++) ref_mem[i] = 8'h00;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.address = '0; bus.write_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, bus.ready}, 32'd0);
        check("rst_rvalid", {31'h0, bus.rvalid}, 32'd0);
        check("rst_error", {31'h0, bus.error}, 32'd0);
        check("rst_rdata", bus.read_data, 32'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        check("ready_before_edge", {31'h0, bus.ready}, 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", {31'h0, bus.ready}, 32'd1);

        // Clear the whole array so contents are defined from here on.
        for (int i = 0; i < SIZE; i += 4) issue(1'b1, 2'b10, 1'b0, 32'(i), 32'h0, "fill");

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hA1B2C3D4, "st_w10");
        issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, "ld_b10", 1'b1, 32'h000000A1);
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, "ld_b11", 1'b1, 32'h000000B2);
        issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, "ld_b12", 1'b1, 32'h000000C3);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "ld_b13", 1'b1, 32'h000000D4);
        issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, "ld_b10_sx", 1'b1, 32'hFFFFFFA1);

        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, "st_w20");
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h12348001, "st_h22");
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "ld_w20", 1'b1, 32'h00008001);
        issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, "ld_h22_sx", 1'b1, 32'hFFFF8001);
        issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, "ld_h22_zx", 1'b1, 32'h00008001);

        issue(1'b0, 2'b10, 1'b0, SIZE - 2, 32'h0, "ld_w_range");
        issue(1'b1, 2'b10, 1'b0, SIZE, 32'hDEADBEEF, "st_w_range");
        issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, "st_rsvd");
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "ld_w10_after", 1'b1, 32'hA1B2C3D4);
        issue(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, "ld_w11_misalign", !TRAP, 32'hA1B2C3D4);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, "ld_rsvd");
        issue(1'b0, 2'b10, 1'b0, 32'hFFFFFFFD, 32'h0, "ld_w_wrap");
        idle(READ_LAT + 1);
        check("hold_rdata", bus.read_data, 32'hA1B2C3D4);

        for (int k = 0; k < 16; k++) begin
            d = $urandom;
            issue(1'b1, 2'b10, 1'b0, 32'h40, d, $sformatf("stream_st%0d", k));
            issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, $sformatf("stream_ld%0d", k), 1'b1, d);
        end
        idle(READ_LAT + 1);

        // Reset with loads in flight; the store before it must survive.
        issue(1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D, "st_w80");
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "inflight0");
        issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, "inflight1");
        reset = 1'b1;
        sb.delete();
        #1;
        check("midrst_rvalid", {31'h0, bus.rvalid}, 32'd0);
        check("midrst_error", {31'h0, bus.error}, 32'd0);
        check("midrst_rdata", bus.read_data, 32'h0);
        check("midrst_ready", {31'h0, bus.ready}, 32'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        check("midrst_ready_pre", {31'h0, bus.ready}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_ready_post", {31'h0, bus.ready}, 32'd1);
        issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, "ld_w80_kept", 1'b1, 32'hCAFEF00D);

        for (int k = 0; k < 400; k++) begin
            w  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            r  = $urandom_range(0, 15);
            if (r < 10)      a = 32'($urandom_range(0, 127));
            else if (r < 15) a = 32'($urandom_range(0, SIZE + 7));
            else             a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            issue(w, sz, 1'($urandom_range(0, 1)), a, $urandom, $sformatf("rand%0d", k));
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(READ_LAT + 2);
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("final_hold", bus.read_data, last_rd);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
